// File: rtl/soc_system_btn_debounce.sv
// Push-button debounce and conditioning stage feeding the button PIO in_port.
//
// Raw key pins are synchronised through a 2-FF chain, then each channel is
// qualified against a shared tick prescaler: a new level must persist for
// DEBOUNCE_TICKS consecutive ticks before it reaches out_port. Registered
// one-cycle strobes flag press, release and long-press (LONG_TICKS ticks held).
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   in_raw         raw asynchronous key pins
//   out_port       debounced level, same polarity as in_raw
//   press_pulse    1-cycle strobe when out_port[i] becomes PRESS_LEVEL
//   release_pulse  1-cycle strobe when out_port[i] leaves PRESS_LEVEL
//   long_pulse     1-cycle strobe when a press has lasted LONG_TICKS ticks
module soc_system_btn_debounce #(
    parameter int unsigned WIDTH          = 2,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned LONG_TICKS     = 1000,
    parameter logic        PRESS_LEVEL    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);

    localparam logic [PW-1:0]    PcntMax  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DcntMax  = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0]    HcntTop  = HW'(LONG_TICKS);
    localparam logic [HW-1:0]    HcntLast = HW'(LONG_TICKS - 1);
    localparam logic [WIDTH-1:0] Released = {WIDTH{~PRESS_LEVEL}};

    typedef enum logic [1:0] {
        StReleasedStable,
        StPressQual,
        StPressedStable,
        StReleaseQual
    } btn_state_e;

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] long_q, long_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tick;
    logic [DW-1:0]    dcnt_q [WIDTH];
    logic [DW-1:0]    dcnt_d [WIDTH];
    logic [HW-1:0]    hcnt_q [WIDTH];
    logic [HW-1:0]    hcnt_d [WIDTH];
    btn_state_e       state_q [WIDTH];
    btn_state_e       state_d [WIDTH];
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] qualify;

    // Shared prescaler; with TICK_DIV=1 the counter is stuck at 0 and tick is always 1.
    always_comb begin
        tick   = (pcnt_q == PcntMax);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    always_comb begin
        mismatch  = '0;
        qualify   = '0;
        out_d     = out_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dcnt_d[i]  = dcnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            state_d[i] = state_q[i];

            mismatch[i] = (s2_q[i] != out_q[i]);
            qualify[i]  = mismatch[i] && tick && (dcnt_q[i] == DcntMax);

            // Any cycle where the synchronised pin agrees restarts qualification.
            if (!mismatch[i]) begin
                dcnt_d[i] = '0;
            end else if (tick) begin
                dcnt_d[i] = qualify[i] ? '0 : dcnt_q[i] + 1'b1;
            end

            unique case (state_q[i])
                StReleasedStable, StPressQual: begin
                    if (!mismatch[i])     state_d[i] = StReleasedStable;
                    else if (qualify[i])  state_d[i] = StPressedStable;
                    else                  state_d[i] = StPressQual;
                end
                StPressedStable, StReleaseQual: begin
                    if (!mismatch[i])     state_d[i] = StPressedStable;
                    else if (qualify[i])  state_d[i] = StReleasedStable;
                    else                  state_d[i] = StReleaseQual;
                end
                default: state_d[i] = StReleasedStable;
            endcase

            // Debounced level is the registered decode of the channel state.
            out_d[i] = (state_d[i] == StPressedStable || state_d[i] == StReleaseQual)
                       ? PRESS_LEVEL : ~PRESS_LEVEL;

            press_d[i]   = qualify[i] && (s2_q[i] == PRESS_LEVEL);
            release_d[i] = qualify[i] && (s2_q[i] != PRESS_LEVEL);

            // Saturating hold counter: fires once on LONG_TICKS-1 -> LONG_TICKS.
            if (out_q[i] != PRESS_LEVEL) begin
                hcnt_d[i] = '0;
            end else if (tick && hcnt_q[i] < HcntTop) begin
                hcnt_d[i] = hcnt_q[i] + 1'b1;
            end
            long_d[i] = (out_q[i] == PRESS_LEVEL) && tick && (hcnt_q[i] == HcntLast);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= Released;
            s2_q      <= Released;
            out_q     <= Released;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            pcnt_q    <= '0;
            dcnt_q    <= '{default: '0};
            hcnt_q    <= '{default: '0};
            state_q   <= '{default: StReleasedStable};
        end else begin
            s1_q      <= in_raw;
            s2_q      <= s1_q;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            state_q   <= state_d;
        end
    end

    assign out_port      = out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_soc_system_btn_debounce.sv
// Self-checking bench for soc_system_btn_debounce. Edge n of a scenario is the
// n-th rising edge after the negedge at which the stimulus was driven.
module tb_soc_system_btn_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_p;
    logic [1:0] in_raw, in_raw_p;
    logic [1:0] out_port, press_pulse, release_pulse, long_pulse;
    logic [1:0] out_p, press_p, release_p, long_p;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        int         cyc;
        logic [1:0] out;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lg;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    soc_system_btn_debounce #(
        .WIDTH(2), .TICK_DIV(1), .DEBOUNCE_TICKS(4), .LONG_TICKS(10), .PRESS_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset(rst), .in_raw(in_raw), .out_port(out_port),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
    );

    soc_system_btn_debounce #(
        .WIDTH(2), .TICK_DIV(5), .DEBOUNCE_TICKS(3), .LONG_TICKS(10), .PRESS_LEVEL(1'b0)
    ) dut_p (
        .clk(clk), .reset(rst_p), .in_raw(in_raw_p), .out_port(out_p),
        .press_pulse(press_p), .release_pulse(release_p), .long_pulse(long_p)
    );

    function automatic ev_t mk_ev(input int c, input logic [1:0] o, input logic [1:0] p,
                                  input logic [1:0] r, input logic [1:0] l);
        ev_t e;
        e.cyc = c; e.out = o; e.pr = p; e.rl = r; e.lg = l;
        return e;
    endfunction

    // Records every cycle on which dut raises any strobe.
    task automatic capture(input int n);
        repeat (n) begin
            @(negedge clk);
            if ((press_pulse | release_pulse | long_pulse) != 2'b00)
                obs_q.push_back(mk_ev(cyc, out_port, press_pulse, release_pulse, long_pulse));
        end
    endtask

    task automatic test_reset;
        ev_t e, o;
        rst = 1'b1; rst_p = 1'b1; in_raw = 2'b11; in_raw_p = 2'b11;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_port, press_pulse, release_pulse, long_pulse} !== 8'b11_00_00_00)
            $display("FAIL reset_state: got out=%b pr=%b rl=%b lg=%b, want out=11 pulses=00",
                     out_port, press_pulse, release_pulse, long_pulse);
        else n_pass++;
        n_checks++;
        if ({out_p, press_p, release_p, long_p} !== 8'b11_00_00_00)
            $display("FAIL reset_state_p: got out=%b pr=%b rl=%b lg=%b, want out=11 pulses=00",
                     out_p, press_p, release_p, long_p);
        else n_pass++;
        rst = 1'b0; rst_p = 1'b0;
        capture(20);
        n_checks++;
        if (out_port !== 2'b11) $display("FAIL reset_idle_out: got %b want 11", out_port);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) $display("FAIL reset_event: got no strobe, want cyc=%0d", e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL reset_event: got cyc=%0d want cyc=%0d", o.cyc, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            $display("FAIL reset_no_strobe: got %0d strobe(s) want 0", obs_q.size());
            obs_q.delete();
        end else n_pass++;
    endtask

    task automatic test_clean_press;
        ev_t e, o;
        int  e0;
        in_raw = 2'b10; e0 = cyc;
        exp_q.push_back(mk_ev(e0 + 6, 2'b10, 2'b01, 2'b00, 2'b00));
        fork
            begin
                repeat (5) @(negedge clk);
                n_checks++;
                if (out_port !== 2'b11) $display("FAIL press_early: got %b want 11", out_port);
                else n_pass++;
                repeat (2) @(negedge clk);
                // Release before the long-press point: no long_pulse may follow.
                in_raw = 2'b11;
                exp_q.push_back(mk_ev(cyc + 6, 2'b11, 2'b00, 2'b01, 2'b00));
            end
            capture(16);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) $display("FAIL press_event: got no strobe, want cyc=%0d", e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL press_event: got cyc=%0d out=%b pr=%b rl=%b lg=%b, want cyc=%0d out=%b pr=%b rl=%b lg=%b",
                             o.cyc, o.out, o.pr, o.rl, o.lg, e.cyc, e.out, e.pr, e.rl, e.lg);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            $display("FAIL press_extra: got %0d extra strobe(s), first cyc=%0d want none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end else n_pass++;
    endtask

    task automatic test_bounce;
        ev_t e, o;
        int  e0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    in_raw = {1'b1, k[0]};
                    repeat (3) @(negedge clk);
                end
                in_raw = 2'b10; e0 = cyc;
                exp_q.push_back(mk_ev(e0 + 6, 2'b10, 2'b01, 2'b00, 2'b00));
                repeat (7) @(negedge clk);
                in_raw = 2'b11;
                exp_q.push_back(mk_ev(cyc + 6, 2'b11, 2'b00, 2'b01, 2'b00));
            end
            capture(30);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) $display("FAIL bounce_event: got no strobe, want cyc=%0d", e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL bounce_event: got cyc=%0d out=%b pr=%b rl=%b lg=%b, want cyc=%0d out=%b pr=%b rl=%b lg=%b",
                             o.cyc, o.out, o.pr, o.rl, o.lg, e.cyc, e.out, e.pr, e.rl, e.lg);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            $display("FAIL bounce_extra: got %0d extra strobe(s), first cyc=%0d want none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end else n_pass++;
    endtask

    task automatic test_long_press;
        ev_t e, o;
        int  e0;
        in_raw = 2'b10; e0 = cyc;
        exp_q.push_back(mk_ev(e0 + 6, 2'b10, 2'b01, 2'b00, 2'b00));
        exp_q.push_back(mk_ev(e0 + 16, 2'b10, 2'b00, 2'b00, 2'b01));
        fork
            begin
                repeat (30) @(negedge clk);
                in_raw = 2'b11;
                exp_q.push_back(mk_ev(cyc + 6, 2'b11, 2'b00, 2'b01, 2'b00));
            end
            capture(45);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) $display("FAIL long_event: got no strobe, want cyc=%0d", e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL long_event: got cyc=%0d out=%b pr=%b rl=%b lg=%b, want cyc=%0d out=%b pr=%b rl=%b lg=%b",
                             o.cyc, o.out, o.pr, o.rl, o.lg, e.cyc, e.out, e.pr, e.rl, e.lg);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            $display("FAIL long_extra: got %0d extra strobe(s), first cyc=%0d want none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end else n_pass++;
    endtask

    task automatic test_simultaneous_reset;
        ev_t e, o;
        int  e0;
        in_raw = 2'b00; e0 = cyc;
        exp_q.push_back(mk_ev(e0 + 6, 2'b00, 2'b11, 2'b00, 2'b00));
        fork
            begin
                repeat (7) @(negedge clk);
                in_raw = 2'b11;
                exp_q.push_back(mk_ev(cyc + 6, 2'b11, 2'b00, 2'b11, 2'b00));
                repeat (8) @(negedge clk);
                // Press both again; reset lands 2 edges before qualification would complete.
                in_raw = 2'b00;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                n_checks++;
                if ({out_port, press_pulse, release_pulse, long_pulse} !== 8'b11_00_00_00)
                    $display("FAIL midqual_reset: got out=%b pr=%b rl=%b lg=%b, want out=11 pulses=00",
                             out_port, press_pulse, release_pulse, long_pulse);
                else n_pass++;
                rst = 1'b0;
                exp_q.push_back(mk_ev(cyc + 6, 2'b00, 2'b11, 2'b00, 2'b00));
            end
            capture(30);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) $display("FAIL simul_event: got no strobe, want cyc=%0d", e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL simul_event: got cyc=%0d out=%b pr=%b rl=%b lg=%b, want cyc=%0d out=%b pr=%b rl=%b lg=%b",
                             o.cyc, o.out, o.pr, o.rl, o.lg, e.cyc, e.out, e.pr, e.rl, e.lg);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            $display("FAIL simul_extra: got %0d extra strobe(s), first cyc=%0d want none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end else n_pass++;
    endtask

    // TICK_DIV=5, DEBOUNCE_TICKS=3. After a change the prescaler sits at 0, so
    // waiting w cycles before the next toggle selects a known phase.
    task automatic test_prescaler;
        int         lat, want, n;
        logic       target;
        logic [1:0] want_pr, want_rl;
        target = 1'b0; in_raw_p = 2'b10; lat = 0;
        do begin @(negedge clk); lat++; end while (out_p[0] !== target && lat < 40);
        n_checks++;
        if (lat < 13 || lat > 17) $display("FAIL presc_warmup: latency %0d want 13..17", lat);
        else n_pass++;
        for (int w = 0; w < 5; w++) begin
            repeat (w) @(negedge clk);
            target = ~target;
            in_raw_p = {1'b1, target};
            n    = 3 + ((5 - ((w + 3) % 5)) % 5);
            want = n + 10;
            lat  = 0;
            do begin @(negedge clk); lat++; end while (out_p[0] !== target && lat < 40);
            n_checks++;
            if (lat < 13 || lat > 17 || lat != want)
                $display("FAIL presc_latency w=%0d: got %0d want %0d (range 13..17)", w, lat, want);
            else n_pass++;
            want_pr = target ? 2'b00 : 2'b01;
            want_rl = target ? 2'b01 : 2'b00;
            n_checks++;
            if ({press_p, release_p} !== {want_pr, want_rl})
                $display("FAIL presc_strobe w=%0d: got pr=%b rl=%b want pr=%b rl=%b",
                         w, press_p, release_p, want_pr, want_rl);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous_reset();
        test_prescaler();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
